// File: rtl/auction_seq_ctrl.sv
// Purpose: sequential first-price sealed-bid auction controller for 2**N bidders; o = {winning_bid, winner}.
// Latency: result registered 1 cycle after the final bid or close; bids accepted one per cycle.
// Backpressure: bid_ready only in COLLECT, duplicates still handshake; result held until res_ready.
module auction_seq_ctrl #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           bid_valid,
    output logic           bid_ready,
    input  logic [N-1:0]   bid_id,
    input  logic [W-1:0]   bid,
    input  logic           close,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N+W-1:0] o,
    output logic           no_bids,
    output logic           dup_err,
    output logic           busy
);

    localparam int NB = 2 ** N;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] bid;
        logic [N-1:0] id;
    } result_t;

    state_t        state, state_nxt;
    logic [NB-1:0] mask, mask_nxt;
    logic [W-1:0]  max_bid, max_bid_nxt;
    logic [N-1:0]  max_id, max_id_nxt;
    logic          have_bid, have_bid_nxt;
    logic          accept, fresh, better, finish;
    result_t       res_q;

    assign bid_ready = (state == COLLECT);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign o         = res_q;

    // Running maximum including this cycle's bid, so close/all-in sees it immediately.
    always_comb begin
        accept       = bid_valid & bid_ready;
        fresh        = accept & ~mask[bid_id];
        better       = ~have_bid || (bid > max_bid) || ((bid == max_bid) && (bid_id < max_id));
        mask_nxt     = mask;
        max_bid_nxt  = max_bid;
        max_id_nxt   = max_id;
        have_bid_nxt = have_bid;
        if (fresh) begin
            mask_nxt[bid_id] = 1'b1;
            have_bid_nxt     = 1'b1;
            if (better) begin
                max_bid_nxt = bid;
                max_id_nxt  = bid_id;
            end
        end
        finish = (state == COLLECT) && ((&mask_nxt) || close);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = COLLECT;
            COLLECT: if (finish)    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '0;
            max_bid  <= '0;
            max_id   <= '0;
            have_bid <= 1'b0;
            res_q    <= '0;
            no_bids  <= 1'b0;
            dup_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask     <= '0;
                        max_bid  <= '0;
                        max_id   <= '0;
                        have_bid <= 1'b0;
                        dup_err  <= 1'b0;
                    end
                end
                COLLECT: begin
                    mask     <= mask_nxt;
                    max_bid  <= max_bid_nxt;
                    max_id   <= max_id_nxt;
                    have_bid <= have_bid_nxt;
                    if (accept && mask[bid_id]) begin
                        dup_err <= 1'b1;
                    end
                    if (finish) begin
                        res_q.bid <= max_bid_nxt;
                        res_q.id  <= max_id_nxt;
                        no_bids   <= ~|mask_nxt;
                    end
                end
                DONE: begin
                    // o deliberately keeps the last result after the transfer.
                    if (res_ready) begin
                        no_bids <= 1'b0;
                        dup_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_auction_seq_ctrl.sv
// Bench for auction_seq_ctrl: scenario tasks drive rounds and push expected results;
// a negedge monitor pops and compares each result as it transfers.
module tb_auction_seq_ctrl;
    localparam int N = 2;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           bid_valid;
    logic           bid_ready;
    logic [N-1:0]   bid_id;
    logic [W-1:0]   bid;
    logic           close;
    logic           res_valid;
    logic           res_ready;
    logic [N+W-1:0] o;
    logic           no_bids;
    logic           dup_err;
    logic           busy;

    typedef struct {
        logic [N+W-1:0] o;
        logic           nb;
        logic           de;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    auction_seq_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bid_valid(bid_valid),
        .bid_ready(bid_ready), .bid_id(bid_id), .bid(bid), .close(close),
        .res_valid(res_valid), .res_ready(res_ready), .o(o),
        .no_bids(no_bids), .dup_err(dup_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and task checks happen 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [W-1:0] b, input logic [N-1:0] id,
                            input logic nb, input logic de);
        exp_t e;
        e.o  = {b, id};
        e.nb = nb;
        e.de = de;
        sb.push_back(e);
    endtask

    task automatic do_bid(input logic [N-1:0] id, input logic [W-1:0] v);
        bid_valid = 1'b1;
        bid_id    = id;
        bid       = v;
        tick();
        bid_valid = 1'b0;
    endtask

    task automatic open_round();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Result transfers on the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got o=%h with no expected result", o);
            end else begin
                mon_e = sb.pop_front();
                if (o !== mon_e.o) begin
                    bad++;
                    $display("FAIL sb_o: got %h want %h", o, mon_e.o);
                end
                total++;
                if (no_bids !== mon_e.nb) begin
                    bad++;
                    $display("FAIL sb_no_bids: got %b want %b", no_bids, mon_e.nb);
                end
                total++;
                if (dup_err !== mon_e.de) begin
                    bad++;
                    $display("FAIL sb_dup_err: got %b want %b", dup_err, mon_e.de);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 0; bid_valid = 0; bid_id = '0; bid = '0; close = 0; res_ready = 0;
        #12;
        total++;
        if ({bid_ready, res_valid, no_bids, dup_err, busy} !== 5'b0 || o !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b nb=%b de=%b busy=%b o=%h want all 0",
                     bid_ready, res_valid, no_bids, dup_err, busy, o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || bid_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b rdy=%b want 0 0", busy, bid_ready);
        end
    endtask

    task automatic test_back_to_back();
        open_round();
        total++;
        if (bid_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_open: got rdy=%b busy=%b want 1 1", bid_ready, busy);
        end
        push_exp(16'h0300, 2'd1, 1'b0, 1'b0);
        do_bid(2'd0, 16'h0010);
        do_bid(2'd1, 16'h0300);
        do_bid(2'd2, 16'h0200);
        total++;
        if (bid_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_mid: got rdy=%b vld=%b want 1 0", bid_ready, res_valid);
        end
        do_bid(2'd3, 16'h0001);
        total++;
        if (res_valid !== 1'b1 || bid_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_latency: got vld=%b rdy=%b want 1 0", res_valid, bid_ready);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got vld=%b busy=%b want 0 0", res_valid, busy);
        end
    endtask

    task automatic test_tie();
        open_round();
        push_exp(16'h00FF, 2'd1, 1'b0, 1'b0);
        do_bid(2'd3, 16'h00FF);
        do_bid(2'd1, 16'h00FF);
        close = 1'b1;
        tick();
        close = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL tie_close: got vld=%b want 1", res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_duplicate();
        open_round();
        push_exp(16'h0005, 2'd2, 1'b0, 1'b1);
        do_bid(2'd2, 16'h0005);
        do_bid(2'd2, 16'h9000);
        do_bid(2'd0, 16'h0001);
        do_bid(2'd1, 16'h0001);
        total++;
        if (res_valid !== 1'b0 || bid_ready !== 1'b1 || dup_err !== 1'b1) begin
            bad++;
            $display("FAIL dup_still_open: got vld=%b rdy=%b de=%b want 0 1 1",
                     res_valid, bid_ready, dup_err);
        end
        do_bid(2'd3, 16'h0001);
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL dup_done: got vld=%b want 1", res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (dup_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dup_clear: got de=%b busy=%b want 0 0", dup_err, busy);
        end
    endtask

    task automatic test_close_empty();
        open_round();
        push_exp(16'h0000, 2'd0, 1'b1, 1'b0);
        close = 1'b1;
        tick();
        close = 1'b0;
        total++;
        if (res_valid !== 1'b1 || no_bids !== 1'b1) begin
            bad++;
            $display("FAIL empty_close: got vld=%b nb=%b want 1 1", res_valid, no_bids);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_close_simultaneous();
        res_ready = 1'b1;
        open_round();
        push_exp(16'h0042, 2'd1, 1'b0, 1'b0);
        close = 1'b1;
        do_bid(2'd1, 16'h0042);
        close = 1'b0;
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL simul_close: got vld=%b want 1", res_valid);
        end
        tick();
        res_ready = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL simul_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_midround_reset();
        open_round();
        do_bid(2'd0, 16'h0010);
        do_bid(2'd1, 16'h0020);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bid_ready, res_valid, no_bids, dup_err, busy} !== 5'b0 || o !== '0) begin
            bad++;
            $display("FAIL midreset_async: got rdy=%b vld=%b nb=%b de=%b busy=%b o=%h want all 0",
                     bid_ready, res_valid, no_bids, dup_err, busy, o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_result: got vld=%b busy=%b want 0 0", res_valid, busy);
        end
        open_round();
        push_exp(16'hFFFF, 2'd0, 1'b0, 1'b0);
        do_bid(2'd0, 16'hFFFF);
        do_bid(2'd3, 16'hFFFF);
        total++;
        if (bid_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_stale_mask: got rdy=%b want 1", bid_ready);
        end
        close = 1'b1;
        tick();
        close = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        open_round();
        push_exp(16'h0007, 2'd1, 1'b0, 1'b1);
        do_bid(2'd1, 16'h0007);
        do_bid(2'd1, 16'h0008);
        close = 1'b1;
        tick();
        close = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            tick();
            total++;
            if (res_valid !== 1'b1 || bid_ready !== 1'b0 || o !== {16'h0007, 2'd1}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b o=%h want 1 0 %h",
                         i, res_valid, bid_ready, o, {16'h0007, 2'd1});
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle: got busy=%b vld=%b want 0 0", busy, res_valid);
        end
        open_round();
        total++;
        if (dup_err !== 1'b0 || bid_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_new_round: got de=%b rdy=%b want 0 1", dup_err, bid_ready);
        end
        push_exp(16'h0000, 2'd0, 1'b1, 1'b0);
        close = 1'b1;
        tick();
        close = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_tie();
        test_duplicate();
        test_close_empty();
        test_close_simultaneous();
        test_midround_reset();
        test_backpressure();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending results want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auction_seq_ctrl.md
# auction_seq_ctrl

Sequential controller for a first-price sealed-bid auction among 2**N bidders. Bids of width W arrive one per cycle over a shared valid/ready port. The block tracks which bidders have submitted, keeps a running maximum, and closes the round on "all bidders in" or an explicit close. It returns winning_bid/winner in the same packed order as the combinational auction datapath, so bench outputs compare directly: winning bid in o[N+W-1:N], winner in o[N-1:0].

## Interface
- N, 2: log2 of bidder count; 2**N bidders, ids 0..2**N-1.
- W, 16: bid width, unsigned.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; single clock domain.
- start  in  1  opens a round; sampled only in IDLE.
- bid_valid  in  1  bid present on bid_id/bid.
- bid_ready  out  1  high only in COLLECT; a bid is accepted on bid_valid & bid_ready.
- bid_id  in  N  submitting bidder index.
- bid  in  W  unsigned bid value.
- close  in  1  forces the round to end early; sampled only in COLLECT.
- res_valid  out  1  result available; held until res_ready.
- res_ready  in  1  result consumer ready.
- o  out  N+W  {winning_bid, winner}; registered, stable while res_valid.
- no_bids  out  1  qualifies o: round closed with zero accepted bids; o = 0.
- dup_err  out  1  sticky per round: a bidder attempted a second bid.
- busy  out  1  high in COLLECT or DONE.

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT when start=1. On this transition:
  - submitted mask (2**N bits) clears.
  - max_bid, max_id, no_bids-tracking and dup_err clear.
- COLLECT, accepted bid with submitted[bid_id]=0:
  - Set submitted[bid_id].
  - Update the maximum if bid > max_bid, or if this is the first accepted bid.
  - Ties go to the lower id. When bid == max_bid and bid_id < max_id, max_id takes bid_id.
- COLLECT, accepted bid with submitted[bid_id]=1:
  - Bid is discarded and dup_err is set.
  - The handshake still completes, so the bus never stalls.
- COLLECT -> DONE when either:
  - the mask becomes all-ones, including via the bid accepted this cycle, or
  - close=1.
- A bid accepted in the same cycle as close is counted before the round closes.
- Entering DONE:
  - o <= {max_bid, max_id}; res_valid <= 1.
  - no_bids <= (mask == 0 after this cycle's update).
- DONE -> IDLE on res_valid & res_ready. res_valid, no_bids and dup_err clear on that edge; o holds its last value.
- start in COLLECT or DONE is ignored. close in IDLE or DONE is ignored.
- Arithmetic: unsigned W-bit compare only; no overflow is possible. bid_id is N bits, so it is always in range.

## Timing
- Reset (async assert, sync release): state=IDLE; bid_ready=0, res_valid=0, o=0, no_bids=0, dup_err=0, busy=0; mask=0.
- start at edge k: COLLECT and bid_ready=1 from cycle k+1.
- Final bid or close at edge m: DONE and res_valid=1 from cycle m+1. bid_ready=0 in that same cycle. Latency is 1 cycle.
- Result and IDLE timing:
  - res_ready may be high before res_valid; the result transfers on the first cycle both are high.
  - The block is in IDLE the cycle after the transfer.
  - The earliest new start is accepted in that IDLE cycle, giving 2 idle-side cycles between rounds.
- Back-to-back bids: one per cycle, no bubbles.
- Minimum round with all 2**N bidders: 1 (start) + 2**N (bids) + 1 (result) cycles.
- Reset mid-round drops the round immediately. No result is produced.

## Test plan
- N=2, W=16; bids id0=0x0010, id1=0x0300, id2=0x0200, id3=0x0001, back-to-back -> res_valid 1 cycle after last bid; o={0x0300,2'd1}; no_bids=0; dup_err=0.
- Tie: id3=0x00FF then id1=0x00FF, then close -> winner=1, winning_bid=0x00FF (lower id wins regardless of arrival order).
- Duplicate: id2=0x0005, id2=0x9000, then id0, id1, id3 = 0x0001 -> dup_err=1; o={0x0005,2'd2}; second id2 bid ignored and round closes only after ids 0, 1, 3.
- Close with no bids: start, close next cycle -> res_valid=1; no_bids=1; o=0. Close with a simultaneous bid id1=0x0042 -> o={0x0042,2'd1}; no_bids=0.
- Backpressure: hold res_ready=0 for 5 cycles -> o and res_valid stable, bid_ready=0, start ignored; res_ready=1 -> IDLE next cycle, then a new round starts cleanly with dup_err cleared.
- Reset: assert rst_n=0 mid-COLLECT after 2 bids -> all outputs 0 asynchronously. After release, a full round with values 0xFFFF (id0) and 0xFFFF (id3) -> winner 0, no stale state.
